// File: rtl/dma_req_initiator.sv
// Per-channel DMA request initiator: queues transfer events, raises a
// registered request per channel and handles ack handshake, timeout and overflow.
module dma_req_initiator #(
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                    DMA_CLK,
    input  logic                    DMA_RST_N,
    input  logic [NUM_CH-1:0]       XFER_EVT,
    input  logic [NUM_CH-1:0]       DMA_ACK,
    input  logic                    ERR_CLR,
    output logic [NUM_CH-1:0]       DMA_REQ,
    output logic [NUM_CH-1:0]       BUSY,
    output logic [NUM_CH*CNT_W-1:0] PENDING,
    output logic [NUM_CH-1:0]       OVERFLOW,
    output logic [NUM_CH-1:0]       TIMEOUT_ERR
);

    localparam int TO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] PEND_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT_REL
    } state_t;

    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_ch
            state_t           r_state;
            logic             r_req;
            logic             r_busy;
            logic             r_ovf;
            logic             r_toErr;
            logic [CNT_W-1:0] r_pend;
            logic [TO_W-1:0]  r_toCnt;

            state_t           w_nextState;
            logic [CNT_W-1:0] w_nextPend;
            logic             w_dec;
            logic             w_timeout;
            logic             w_ovfSet;

            // Next-state values are computed here so every output can be
            // registered from them, keeping inputs off any output path.
            always_comb begin
                w_dec       = (r_state == ST_REQ) && DMA_ACK[g];
                w_timeout   = (r_state == ST_REQ) && !DMA_ACK[g] && (r_toCnt == TO_LAST);
                w_ovfSet    = XFER_EVT[g] && !w_dec && (r_pend == PEND_MAX);
                w_nextPend  = r_pend;
                w_nextState = r_state;

                if (XFER_EVT[g] && !w_dec) begin
                    if (r_pend != PEND_MAX) begin
                        w_nextPend = r_pend + 1'b1;
                    end
                end else if (w_dec && !XFER_EVT[g]) begin
                    w_nextPend = r_pend - 1'b1;
                end

                case (r_state)
                    ST_IDLE: begin
                        if ((r_pend != '0) && !DMA_ACK[g]) begin
                            w_nextState = ST_REQ;
                        end
                    end
                    ST_REQ: begin
                        if (w_dec || w_timeout) begin
                            w_nextState = ST_WAIT_REL;
                        end
                    end
                    ST_WAIT_REL: begin
                        if (!DMA_ACK[g]) begin
                            w_nextState = ST_IDLE;
                        end
                    end
                    default: w_nextState = ST_IDLE;
                endcase
            end

            // A timeout leaves the pending count alone so the transfer retries;
            // a same-cycle set beats the error clear.
            always_ff @(posedge DMA_CLK or negedge DMA_RST_N) begin
                if (!DMA_RST_N) begin
                    r_state <= ST_IDLE;
                    r_req   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_ovf   <= 1'b0;
                    r_toErr <= 1'b0;
                    r_pend  <= '0;
                    r_toCnt <= '0;
                end else begin
                    r_state <= w_nextState;
                    r_pend  <= w_nextPend;
                    r_req   <= (w_nextState == ST_REQ);
                    r_busy  <= (w_nextState != ST_IDLE) || (w_nextPend != '0);

                    if ((r_state == ST_REQ) && (w_nextState == ST_REQ)) begin
                        r_toCnt <= r_toCnt + 1'b1;
                    end else begin
                        r_toCnt <= '0;
                    end

                    if (w_ovfSet) begin
                        r_ovf <= 1'b1;
                    end else if (ERR_CLR) begin
                        r_ovf <= 1'b0;
                    end

                    if (w_timeout) begin
                        r_toErr <= 1'b1;
                    end else if (ERR_CLR) begin
                        r_toErr <= 1'b0;
                    end
                end
            end

            assign DMA_REQ[g]                  = r_req;
            assign BUSY[g]                     = r_busy;
            assign OVERFLOW[g]                 = r_ovf;
            assign TIMEOUT_ERR[g]              = r_toErr;
            assign PENDING[g*CNT_W +: CNT_W]   = r_pend;
        end
    endgenerate

endmodule
